// File: rtl/id_stage_front_pkg.sv
// Shared decode-stage definitions for the LA32R pipeline: opcode and
// exception-code constants, reset values, the decoder output bundle and
// the RAW-compare helper used by the decode interlock.
package id_stage_front_pkg;

    // Reset vector used by the fetch stage; decode itself resets its PC to 0.
    localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
    localparam logic [31:0] DS_PC_RESET = 32'h0000_0000;

    // Major opcodes in inst[31:26].
    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;

    // Store opcodes in inst[31:22].
    localparam logic [9:0] OP_ST_B = 10'h0a4;
    localparam logic [9:0] OP_ST_H = 10'h0a5;
    localparam logic [9:0] OP_ST_W = 10'h0a6;

    // 1RI20 opcodes in inst[31:25].
    localparam logic [6:0] OP_LU12I_W   = 7'h0a;
    localparam logic [6:0] OP_PCADDU12I = 7'h0e;

    // Trap opcodes in inst[31:15].
    localparam logic [16:0] OP_SYSCALL = 17'h00056;
    localparam logic [16:0] OP_BREAK   = 17'h00054;

    // Exception codes.
    localparam logic [5:0] ECODE_NONE = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;

    // Branch class of the decoded instruction.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_B    = 3'd3,
        BR_BL   = 3'd4,
        BR_JIRL = 3'd5
    } br_type_e;

    // Everything the top needs from the instruction word.
    typedef struct packed {
        br_type_e   br_type;
        logic       use_rj;      // rj is a real source operand
        logic       use_rk;      // rk is a real source operand (3R groups)
        logic       src2_is_rd;  // second read port reads rd (beq/bne/stores)
        logic [4:0] rj;          // read address 1
        logic [4:0] src2;        // read address 2 (rk or rd)
        logic [4:0] dest;        // write target, 0 when nothing is written
        logic       is_sys;
        logic       is_brk;
    } dec_t;

    // True when a non-zero source matches any non-zero in-flight destination.
    function automatic logic raw_hit(input logic [4:0] src,
                                     input logic [4:0] es_dest,
                                     input logic [4:0] ms_dest,
                                     input logic [4:0] ws_dest);
        logic hit;
        hit = 1'b0;
        if (src != 5'd0) begin
            hit = ((es_dest != 5'd0) && (src == es_dest)) ||
                  ((ms_dest != 5'd0) && (src == ms_dest)) ||
                  ((ws_dest != 5'd0) && (src == ws_dest));
        end
        return hit;
    endfunction

endpackage

// File: rtl/id_stage_front_if.sv
// Handshake bundles around the decode stage.
//
// Valid/ready rule for both bundles: a transfer happens on a rising clock
// edge where the producer's valid and the consumer's allowin are both high.
// The producer holds its payload stable while valid is high and allowin is
// low; allowin may depend combinationally on the consumer's own state only.

// Fetch -> decode bundle. Fetch is the master, decode the slave.
interface id_fs_ds_if;
    logic        fs_to_ds_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        fs_adef_ex;
    logic        ds_allowin;

    modport master (
        output fs_to_ds_valid,
        output fs_inst,
        output fs_pc,
        output fs_adef_ex,
        input  ds_allowin
    );

    modport slave (
        input  fs_to_ds_valid,
        input  fs_inst,
        input  fs_pc,
        input  fs_adef_ex,
        output ds_allowin
    );
endinterface

// Decode -> execute bundle. Decode is the master, execute the slave.
interface id_ds_es_if;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic [31:0] ds_rj_value;
    logic [31:0] ds_rkd_value;
    logic [4:0]  ds_dest;
    logic        ds_ex;
    logic [5:0]  ds_ecode;

    modport master (
        output ds_to_es_valid,
        input  es_allowin,
        output ds_pc,
        output ds_inst,
        output ds_rj_value,
        output ds_rkd_value,
        output ds_dest,
        output ds_ex,
        output ds_ecode
    );

    modport slave (
        input  ds_to_es_valid,
        output es_allowin,
        input  ds_pc,
        input  ds_inst,
        input  ds_rj_value,
        input  ds_rkd_value,
        input  ds_dest,
        input  ds_ex,
        input  ds_ecode
    );
endinterface

// File: rtl/id_stage_front_decoder.sv
// Combinational instruction decoder for the decode front end: branch class,
// source usage, register-file read addresses, destination and trap flags.
module id_decoder
    import id_stage_front_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [4:0] w_rd;
    logic [4:0] w_rj;
    logic [4:0] w_rk;
    logic       w_is_beq;
    logic       w_is_bne;
    logic       w_is_b;
    logic       w_is_bl;
    logic       w_is_jirl;
    logic       w_is_store;
    logic       w_is_lu12i;
    logic       w_is_pcadd;
    logic       w_is_3r;
    logic       w_is_sys;
    logic       w_is_brk;
    logic       w_no_write;
    logic [4:0] w_dest_raw;

    assign w_rd = i_inst[4:0];
    assign w_rj = i_inst[9:5];
    assign w_rk = i_inst[14:10];

    assign w_is_beq   = (i_inst[31:26] == OP_BEQ);
    assign w_is_bne   = (i_inst[31:26] == OP_BNE);
    assign w_is_b     = (i_inst[31:26] == OP_B);
    assign w_is_bl    = (i_inst[31:26] == OP_BL);
    assign w_is_jirl  = (i_inst[31:26] == OP_JIRL);
    assign w_is_store = (i_inst[31:22] == OP_ST_B) ||
                        (i_inst[31:22] == OP_ST_H) ||
                        (i_inst[31:22] == OP_ST_W);
    assign w_is_lu12i = (i_inst[31:25] == OP_LU12I_W);
    assign w_is_pcadd = (i_inst[31:25] == OP_PCADDU12I);
    assign w_is_sys   = (i_inst[31:15] == OP_SYSCALL);
    assign w_is_brk   = (i_inst[31:15] == OP_BREAK);

    // 3R groups share a zero top field and a non-zero group select.
    assign w_is_3r = (i_inst[31:22] == 10'd0) && (i_inst[21:20] != 2'd0);

    // Instructions that never write the register file.
    assign w_no_write = w_is_beq | w_is_bne | w_is_b | w_is_store |
                        w_is_sys | w_is_brk;

    // bl links into r1; everything else that writes targets rd.
    assign w_dest_raw = w_is_bl ? 5'd1 : w_rd;

    // Classify the branch and assemble the decode bundle.
    always_comb begin
        o_dec = '0;
        if (w_is_beq) begin
            o_dec.br_type = BR_BEQ;
        end else if (w_is_bne) begin
            o_dec.br_type = BR_BNE;
        end else if (w_is_b) begin
            o_dec.br_type = BR_B;
        end else if (w_is_bl) begin
            o_dec.br_type = BR_BL;
        end else if (w_is_jirl) begin
            o_dec.br_type = BR_JIRL;
        end else begin
            o_dec.br_type = BR_NONE;
        end
        o_dec.use_rj     = ~(w_is_b | w_is_bl | w_is_lu12i | w_is_pcadd);
        o_dec.use_rk     = w_is_3r & ~w_is_sys & ~w_is_brk;
        o_dec.src2_is_rd = w_is_beq | w_is_bne | w_is_store;
        o_dec.rj         = w_rj;
        o_dec.src2       = o_dec.src2_is_rd ? w_rd : w_rk;
        o_dec.dest       = (w_no_write || (w_dest_raw == 5'd0)) ? 5'd0 : w_dest_raw;
        o_dec.is_sys     = w_is_sys;
        o_dec.is_brk     = w_is_brk;
    end

endmodule

// File: rtl/id_stage_front.sv
// Decode-stage front end: pipeline register behind fetch, register-file
// read, RAW interlock against EX/MEM/WB, branch resolution back to fetch,
// exception merge, and the valid/allowin hand-off to EX.
module id_stage_front
    import id_stage_front_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_resetn,
    id_fs_ds_if.slave    fs_if,
    id_ds_es_if.master   es_if,
    output logic [4:0]   o_rf_raddr1,
    output logic [4:0]   o_rf_raddr2,
    input  logic [31:0]  i_rf_rdata1,
    input  logic [31:0]  i_rf_rdata2,
    input  logic [4:0]   i_es_dest,
    input  logic [4:0]   i_ms_dest,
    input  logic [4:0]   i_ws_dest,
    input  logic         i_wb_ex,
    input  logic         i_ertn_flush,
    output logic         o_br_taken,
    output logic [31:0]  o_br_target,
    output logic         o_ds_valid
);

    // Pipeline register holding the accepted fetch bundle.
    logic        r_ds_valid;
    logic [31:0] r_ds_pc;
    logic [31:0] r_ds_inst;
    logic        r_ds_adef;

    dec_t        w_dec;
    logic        w_flush;
    logic        w_hz_src1;
    logic        w_hz_src2;
    logic        w_hazard;
    logic        w_ds_ex;
    logic [5:0]  w_ecode;
    logic        w_ready_go;
    logic        w_allowin;
    logic        w_to_es_valid;
    logic        w_rs_eq;
    logic        w_br_cond;
    logic        w_br_taken;
    logic [31:0] w_offs16;
    logic [31:0] w_offs26;
    logic [31:0] w_br_base;
    logic [31:0] w_br_offs;

    id_decoder u_decoder (
        .i_inst (r_ds_inst),
        .o_dec  (w_dec)
    );

    assign w_flush = i_wb_ex | i_ertn_flush;

    // Register-file reads are combinational on the held instruction, so a
    // stalled bundle sees fresh operands every cycle.
    assign o_rf_raddr1 = w_dec.rj;
    assign o_rf_raddr2 = w_dec.src2;

    // RAW interlock: only sources the instruction really reads can stall it.
    assign w_hz_src1 = w_dec.use_rj &
                       raw_hit(w_dec.rj, i_es_dest, i_ms_dest, i_ws_dest);
    assign w_hz_src2 = (w_dec.use_rk | w_dec.src2_is_rd) &
                       raw_hit(w_dec.src2, i_es_dest, i_ms_dest, i_ws_dest);
    assign w_hazard  = w_hz_src1 | w_hz_src2;

    // Any attached exception lets the bundle leave without waiting for
    // operands; it will never execute anyway.
    assign w_ds_ex = r_ds_adef | w_dec.is_sys | w_dec.is_brk;

    // Exception code with ADEF taking priority over SYS over BRK.
    always_comb begin
        w_ecode = ECODE_NONE;
        if (r_ds_adef) begin
            w_ecode = ECODE_ADEF;
        end else if (w_dec.is_sys) begin
            w_ecode = ECODE_SYS;
        end else if (w_dec.is_brk) begin
            w_ecode = ECODE_BRK;
        end
    end

    assign w_ready_go    = ~w_hazard | w_ds_ex;
    assign w_allowin     = ~r_ds_valid | (w_ready_go & es_if.es_allowin);
    assign w_to_es_valid = r_ds_valid & w_ready_go & ~w_flush;

    // Branch condition from the decoded class and the compared operands.
    assign w_rs_eq = (i_rf_rdata1 == i_rf_rdata2);
    always_comb begin
        w_br_cond = 1'b0;
        case (w_dec.br_type)
            BR_BEQ:  w_br_cond = w_rs_eq;
            BR_BNE:  w_br_cond = ~w_rs_eq;
            BR_B:    w_br_cond = 1'b1;
            BR_BL:   w_br_cond = 1'b1;
            BR_JIRL: w_br_cond = 1'b1;
            default: w_br_cond = 1'b0;
        endcase
    end

    // The redirect fires only in the cycle the branch hands off to EX.
    assign w_br_taken = r_ds_valid & w_ready_go & es_if.es_allowin &
                        ~w_ds_ex & ~w_flush & w_br_cond;

    // Branch adder: pc- or rj-relative with a 16- or 26-bit word offset.
    assign w_offs16  = {{14{r_ds_inst[25]}}, r_ds_inst[25:10], 2'b00};
    assign w_offs26  = {{4{r_ds_inst[9]}}, r_ds_inst[9:0], r_ds_inst[25:10], 2'b00};
    assign w_br_base = (w_dec.br_type == BR_JIRL) ? i_rf_rdata1 : r_ds_pc;
    assign w_br_offs = ((w_dec.br_type == BR_B) || (w_dec.br_type == BR_BL)) ?
                       w_offs26 : w_offs16;

    assign o_br_taken  = w_br_taken;
    assign o_br_target = w_br_base + w_br_offs;
    assign o_ds_valid  = r_ds_valid;

    assign fs_if.ds_allowin = w_allowin;

    assign es_if.ds_to_es_valid = w_to_es_valid;
    assign es_if.ds_pc          = r_ds_pc;
    assign es_if.ds_inst        = r_ds_inst;
    assign es_if.ds_rj_value    = i_rf_rdata1;
    assign es_if.ds_rkd_value   = i_rf_rdata2;
    assign es_if.ds_dest        = w_dec.dest;
    assign es_if.ds_ex          = w_ds_ex;
    assign es_if.ds_ecode       = w_ecode;

    // Accept a new bundle when allowed; a flush empties the stage at once,
    // and a taken branch discards the wrong-path bundle fetched alongside it.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_ds_valid <= 1'b0;
            r_ds_pc    <= DS_PC_RESET;
            r_ds_inst  <= 32'd0;
            r_ds_adef  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_ds_valid <= 1'b0;
            end else if (w_allowin) begin
                r_ds_valid <= fs_if.fs_to_ds_valid & ~w_br_taken;
            end
            if (w_allowin) begin
                r_ds_pc   <= fs_if.fs_pc;
                r_ds_inst <= fs_if.fs_inst;
                r_ds_adef <= fs_if.fs_adef_ex;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_front.sv
// Testbench for id_stage_front: directed scenarios plus a random
// back-to-back stream checked against an expected queue.
module tb_id_stage_front;

    logic        clk;
    logic        resetn;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  es_dest;
    logic [4:0]  ms_dest;
    logic [4:0]  ws_dest;
    logic        wb_ex;
    logic        ertn_flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_valid;

    logic [31:0] rf [32];
    logic [63:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    id_fs_ds_if fs_if ();
    id_ds_es_if es_if ();

    id_stage_front dut (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .fs_if        (fs_if),
        .es_if        (es_if),
        .o_rf_raddr1  (rf_raddr1),
        .o_rf_raddr2  (rf_raddr2),
        .i_rf_rdata1  (rf_rdata1),
        .i_rf_rdata2  (rf_rdata2),
        .i_es_dest    (es_dest),
        .i_ms_dest    (ms_dest),
        .i_ws_dest    (ws_dest),
        .i_wb_ex      (wb_ex),
        .i_ertn_flush (ertn_flush),
        .o_br_taken   (br_taken),
        .o_br_target  (br_target),
        .o_ds_valid   (ds_valid)
    );

    // Asynchronous register-file model.
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction builders.
    function automatic logic [31:0] enc_3r(input logic [16:0] op, input logic [4:0] rk,
                                           input logic [4:0] rj, input logic [4:0] rd);
        return {op, rk, rj, rd};
    endfunction

    function automatic logic [31:0] enc_2ri16(input logic [5:0] op, input logic [15:0] offs,
                                              input logic [4:0] rj, input logic [4:0] rd);
        return {op, offs, rj, rd};
    endfunction

    // Independent RAW model for an add.w held in decode.
    function automatic logic tb_hit(input logic [4:0] src, input logic [4:0] e,
                                    input logic [4:0] m, input logic [4:0] w);
        return (src != 5'd0) && ((src == e) || (src == m) || (src == w));
    endfunction

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fs(input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic adef);
        fs_if.fs_to_ds_valid = v;
        fs_if.fs_pc          = pc;
        fs_if.fs_inst        = inst;
        fs_if.fs_adef_ex     = adef;
    endtask

    task automatic idle(input int n);
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        es_if.es_allowin = 1'b1;
        es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
        wb_ex = 1'b0; ertn_flush = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(3);
        @(negedge clk);
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL reset_ds_valid: got %b expected 0", ds_valid); end
        checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL reset_to_es_valid: got %b expected 0", es_if.ds_to_es_valid); end
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken: got %b expected 0", br_taken); end
        checks++; if (fs_if.ds_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", fs_if.ds_allowin); end
        checks++; if (es_if.ds_pc !== 32'd0) begin errors++; $display("FAIL reset_ds_pc: got %h expected 0", es_if.ds_pc); end
        checks++; if (es_if.ds_inst !== 32'd0) begin errors++; $display("FAIL reset_ds_inst: got %h expected 0", es_if.ds_inst); end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_straight();
        drive_fs(1'b1, 32'h1c00_0000, enc_3r(17'h00020, 5'd2, 5'd1, 5'd3), 1'b0);
        @(negedge clk);
        checks++; if (fs_if.ds_allowin !== 1'b1) begin errors++; $display("FAIL straight_allowin: got %b expected 1", fs_if.ds_allowin); end
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL straight_valid: got %b expected 1", es_if.ds_to_es_valid); end
        checks++; if (es_if.ds_dest !== 5'd3) begin errors++; $display("FAIL straight_dest: got %0d expected 3", es_if.ds_dest); end
        checks++; if (rf_raddr1 !== 5'd1) begin errors++; $display("FAIL straight_raddr1: got %0d expected 1", rf_raddr1); end
        checks++; if (rf_raddr2 !== 5'd2) begin errors++; $display("FAIL straight_raddr2: got %0d expected 2", rf_raddr2); end
        checks++; if (es_if.ds_pc !== 32'h1c00_0000) begin errors++; $display("FAIL straight_pc: got %h expected 1c000000", es_if.ds_pc); end
        checks++; if (es_if.ds_ex !== 1'b0) begin errors++; $display("FAIL straight_ex: got %b expected 0", es_if.ds_ex); end
        checks++; if (es_if.ds_rkd_value !== rf[2]) begin errors++; $display("FAIL straight_rkd: got %h expected %h", es_if.ds_rkd_value, rf[2]); end
        step();
        @(negedge clk);
        checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL straight_drain: got %b expected 0", es_if.ds_to_es_valid); end
        idle(1);
    endtask

    task automatic test_raw_stall();
        es_dest = 5'd3;
        drive_fs(1'b1, 32'h1c00_0004, enc_3r(17'h00022, 5'd5, 5'd3, 5'd4), 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (fs_if.ds_allowin !== 1'b0) begin errors++; $display("FAIL raw_allowin: got %b expected 0", fs_if.ds_allowin); end
            checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL raw_valid: got %b expected 0", es_if.ds_to_es_valid); end
            checks++; if (es_if.ds_pc !== 32'h1c00_0004) begin errors++; $display("FAIL raw_hold_pc: got %h expected 1c000004", es_if.ds_pc); end
            step();
        end
        es_dest = 5'd0;
        @(negedge clk);
        checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL raw_release_valid: got %b expected 1", es_if.ds_to_es_valid); end
        checks++; if (fs_if.ds_allowin !== 1'b1) begin errors++; $display("FAIL raw_release_allowin: got %b expected 1", fs_if.ds_allowin); end
        checks++; if (es_if.ds_dest !== 5'd4) begin errors++; $display("FAIL raw_dest: got %0d expected 4", es_if.ds_dest); end
        idle(1);
    endtask

    task automatic test_beq();
        rf[4] = 32'd7; rf[5] = 32'd7;
        drive_fs(1'b1, 32'h1c00_0010, enc_2ri16(6'h16, 16'd4, 5'd4, 5'd5), 1'b0);
        step();
        drive_fs(1'b1, 32'h1c00_0014, enc_3r(17'h00020, 5'd2, 5'd1, 5'd3), 1'b0);
        @(negedge clk);
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b expected 1", br_taken); end
        checks++; if (br_target !== 32'h1c00_0020) begin errors++; $display("FAIL beq_target: got %h expected 1c000020", br_target); end
        checks++; if (es_if.ds_dest !== 5'd0) begin errors++; $display("FAIL beq_dest: got %0d expected 0", es_if.ds_dest); end
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL beq_drop_wrong_path: got %b expected 0", ds_valid); end
        rf[5] = 32'd8;
        drive_fs(1'b1, 32'h1c00_0040, enc_2ri16(6'h16, 16'd4, 5'd4, 5'd5), 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %b expected 0", br_taken); end
        checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL beq_nt_valid: got %b expected 1", es_if.ds_to_es_valid); end
        idle(1);
    endtask

    task automatic test_jirl_bl();
        rf[6] = 32'h1c00_0100;
        drive_fs(1'b1, 32'h1c00_0030, enc_2ri16(6'h13, 16'hffff, 5'd6, 5'd1), 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL jirl_taken: got %b expected 1", br_taken); end
        checks++; if (br_target !== 32'h1c00_00fc) begin errors++; $display("FAIL jirl_target: got %h expected 1c0000fc", br_target); end
        checks++; if (es_if.ds_dest !== 5'd1) begin errors++; $display("FAIL jirl_dest: got %0d expected 1", es_if.ds_dest); end
        idle(1);
        drive_fs(1'b1, 32'h1c00_0200, {6'h15, 16'hffff, 10'h3ff}, 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL bl_taken: got %b expected 1", br_taken); end
        checks++; if (br_target !== 32'h1c00_01fc) begin errors++; $display("FAIL bl_target: got %h expected 1c0001fc", br_target); end
        checks++; if (es_if.ds_dest !== 5'd1) begin errors++; $display("FAIL bl_dest: got %0d expected 1", es_if.ds_dest); end
        idle(1);
    endtask

    task automatic test_exceptions();
        logic [31:0] sys_inst;
        logic [31:0] brk_inst;
        logic [5:0]  ecode_exp [3];
        logic        adef_in [3];
        logic [31:0] inst_in [3];
        sys_inst = {17'h00056, 5'd0, 5'd3, 5'd0};
        brk_inst = {17'h00054, 15'd0};
        inst_in[0] = sys_inst; adef_in[0] = 1'b1; ecode_exp[0] = 6'h08;
        inst_in[1] = sys_inst; adef_in[1] = 1'b0; ecode_exp[1] = 6'h0b;
        inst_in[2] = brk_inst; adef_in[2] = 1'b0; ecode_exp[2] = 6'h0c;
        for (int i = 0; i < 3; i++) begin
            es_dest = 5'd3;
            drive_fs(1'b1, 32'h1c00_0300 + 32'(i * 4), inst_in[i], adef_in[i]);
            step();
            drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
            checks++; if (es_if.ds_ex !== 1'b1) begin errors++; $display("FAIL exc%0d_ex: got %b expected 1", i, es_if.ds_ex); end
            checks++; if (es_if.ds_ecode !== ecode_exp[i]) begin errors++; $display("FAIL exc%0d_ecode: got %h expected %h", i, es_if.ds_ecode, ecode_exp[i]); end
            checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL exc%0d_no_stall: got %b expected 1", i, es_if.ds_to_es_valid); end
            checks++; if (es_if.ds_dest !== 5'd0) begin errors++; $display("FAIL exc%0d_dest: got %0d expected 0", i, es_if.ds_dest); end
            idle(1);
        end
    endtask

    task automatic test_flush();
        es_dest = 5'd3;
        drive_fs(1'b1, 32'h1c00_0400, enc_3r(17'h00022, 5'd5, 5'd3, 5'd4), 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        wb_ex = 1'b1;
        @(negedge clk);
        checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", es_if.ds_to_es_valid); end
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL flush_br: got %b expected 0", br_taken); end
        step();
        wb_ex = 1'b0; es_dest = 5'd0;
        @(negedge clk);
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got %b expected 0", ds_valid); end
        idle(1);
        rf[4] = 32'd9; rf[5] = 32'd9;
        drive_fs(1'b1, 32'h1c00_0500, enc_2ri16(6'h16, 16'd4, 5'd4, 5'd5), 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        ertn_flush = 1'b1;
        @(negedge clk);
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL flush_beats_branch: got %b expected 0", br_taken); end
        checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL ertn_valid: got %b expected 0", es_if.ds_to_es_valid); end
        step();
        ertn_flush = 1'b0;
        @(negedge clk);
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL ertn_cleared: got %b expected 0", ds_valid); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        es_if.es_allowin = 1'b0;
        drive_fs(1'b1, 32'h1c00_0600, enc_3r(17'h00020, 5'd2, 5'd1, 5'd3), 1'b0);
        step();
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++; if (fs_if.ds_allowin !== 1'b0) begin errors++; $display("FAIL mid_stall_allowin: got %b expected 0", fs_if.ds_allowin); end
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", ds_valid); end
        checks++; if (es_if.ds_pc !== 32'd0) begin errors++; $display("FAIL mid_reset_pc: got %h expected 0", es_if.ds_pc); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic        pending;
        logic [31:0] next_pc;
        logic [63:0] head;
        logic        exp_go;
        logic        exp_allow;
        logic [4:0]  exp_dest;
        pending = 1'b0;
        next_pc = 32'h1c00_1000;
        for (int c = 0; c < 400; c++) begin
            es_if.es_allowin = ($urandom_range(0, 3) != 0);
            es_dest = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            ms_dest = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            ws_dest = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive_fs(1'b1, next_pc, enc_3r(17'h00020, 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))), 1'b0);
                    pending = 1'b1;
                end else begin
                    fs_if.fs_to_ds_valid = 1'b0;
                end
            end
            @(negedge clk);
            exp_go = 1'b0;
            head = 64'd0;
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                exp_go = !(tb_hit(head[9:5], es_dest, ms_dest, ws_dest) ||
                           tb_hit(head[14:10], es_dest, ms_dest, ws_dest));
            end
            exp_allow = (exp_q.size() == 0) || (exp_go && es_if.es_allowin);
            checks++; if (es_if.ds_to_es_valid !== exp_go) begin errors++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, es_if.ds_to_es_valid, exp_go); end
            checks++; if (fs_if.ds_allowin !== exp_allow) begin errors++; $display("FAIL b2b_allowin c%0d: got %b expected %b", c, fs_if.ds_allowin, exp_allow); end
            checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL b2b_br c%0d: got %b expected 0", c, br_taken); end
            if (exp_go && es_if.es_allowin) begin
                head = exp_q.pop_front();
                exp_dest = head[4:0];
                checks++; if (es_if.ds_pc !== head[63:32]) begin errors++; $display("FAIL b2b_pc c%0d: got %h expected %h", c, es_if.ds_pc, head[63:32]); end
                checks++; if (es_if.ds_inst !== head[31:0]) begin errors++; $display("FAIL b2b_inst c%0d: got %h expected %h", c, es_if.ds_inst, head[31:0]); end
                checks++; if (es_if.ds_dest !== exp_dest) begin errors++; $display("FAIL b2b_dest c%0d: got %0d expected %0d", c, es_if.ds_dest, exp_dest); end
            end
            if (fs_if.fs_to_ds_valid && exp_allow) begin
                exp_q.push_back({fs_if.fs_pc, fs_if.fs_inst});
                pending = 1'b0;
                next_pc = next_pc + 32'd4;
            end
            step();
        end
        idle(4);
    endtask

    // Test sequence and final report.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[0] = 32'd0;
        resetn = 1'b0;
        drive_fs(1'b0, 32'd0, 32'd0, 1'b0);
        es_if.es_allowin = 1'b1;
        es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
        wb_ex = 1'b0; ertn_flush = 1'b0;
        test_reset();
        test_straight();
        test_raw_stall();
        test_beq();
        test_jirl_bl();
        test_exceptions();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
